// File: rtl/pixel_window_reader.sv
// rtl/pixel_window_reader.sv - fetches a 3x3 pixel neighbourhood from 32-bit-word image RAM
// Optional build macro: WINDOW_BORDER_CLAMP_EN (edge replication instead of zero fill for OOB neighbours)
module pixel_window_reader #(
    parameter int RAM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    output logic [15:0] ram_addr,
    input  logic [31:0] ram_data,
    output logic        busy,
    output logic        done,
    output logic [71:0] window
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPTURE, S_DONE} state_t;

    typedef struct packed {
        logic        oob;
        logic [1:0]  lane;
        logic [15:0] addr;
    } nbr_t;

    localparam logic [1:0] WAIT_INIT = 2'(RAM_LATENCY - 2);

    // Neighbour i (raster order) of centre (cx, cy); the address always uses the clamped coordinate.
    function automatic nbr_t nbr(input logic [8:0] cx, input logic [8:0] cy, input logic [3:0] i);
        logic signed [10:0] dx, dy, nx, ny;
        logic [8:0]         rx, ry;
        nbr_t               r;
        case (i)
            4'd0, 4'd3, 4'd6: dx = -11'sd1;
            4'd1, 4'd4, 4'd7: dx = 11'sd0;
            default:          dx = 11'sd1;
        endcase
        if (i < 4'd3)      dy = -11'sd1;
        else if (i < 4'd6) dy = 11'sd0;
        else               dy = 11'sd1;
        nx = $signed({2'b00, cx}) + dx;
        ny = $signed({2'b00, cy}) + dy;
        if (nx < 11'sd0)        rx = 9'd0;
        else if (nx > 11'sd511) rx = 9'd511;
        else                    rx = nx[8:0];
        if (ny < 11'sd0)        ry = 9'd0;
        else if (ny > 11'sd511) ry = 9'd511;
        else                    ry = ny[8:0];
        r.oob  = (nx < 11'sd0) || (nx > 11'sd511) || (ny < 11'sd0) || (ny > 11'sd511);
        r.lane = rx[1:0];
        r.addr = {ry, rx[8:2]};
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        oob_q, oob_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] addr_d;
    logic        busy_d, done_d;
    logic [71:0] win_d;
    logic [7:0]  sel_byte, pix;
    nbr_t        nb_start, nb_next;

    assign nb_start = nbr(x, y, 4'd0);
    assign nb_next  = nbr(x_q, y_q, idx_q + 4'd1);
    assign sel_byte = ram_data[{lane_q, 3'b000} +: 8];

`ifdef WINDOW_BORDER_CLAMP_EN
    assign pix = sel_byte;
`else
    assign pix = oob_q ? 8'h00 : sel_byte;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            x_q      <= 9'd0;
            y_q      <= 9'd0;
            wcnt_q   <= 2'd0;
            oob_q    <= 1'b0;
            lane_q   <= 2'd0;
            ram_addr <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            window   <= 72'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            wcnt_q   <= wcnt_d;
            oob_q    <= oob_d;
            lane_q   <= lane_d;
            ram_addr <= addr_d;
            busy     <= busy_d;
            done     <= done_d;
            window   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        wcnt_d  = wcnt_q;
        oob_d   = oob_q;
        lane_d  = lane_q;
        addr_d  = ram_addr;
        busy_d  = busy;
        done_d  = 1'b0;
        win_d   = window;
        case (state_q)
            // The DONE cycle's closing edge doubles as the earliest start sample, so a held start re-triggers immediately.
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    idx_d   = 4'd0;
                    addr_d  = nb_start.addr;
                    oob_d   = nb_start.oob;
                    lane_d  = nb_start.lane;
                    busy_d  = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (RAM_LATENCY == 1) begin
                    state_d = S_CAPTURE;
                end else begin
                    wcnt_d  = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 2'd0) state_d = S_CAPTURE;
                else                wcnt_d  = wcnt_q - 2'd1;
            end
            S_CAPTURE: begin
                win_d[{idx_q, 3'b000} +: 8] = pix;
                if (idx_q == 4'd8) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    addr_d  = nb_next.addr;
                    oob_d   = nb_next.oob;
                    lane_d  = nb_next.lane;
                    state_d = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
